// File: rtl/instr_mem.sv
// Parametrised instruction memory: self-initialising boot image, 1-cycle fetch
// handshake, word-wise reprogramming. Optional parity storage via INSTR_MEM_PARITY_EN.
module instr_mem #(
  parameter int          DATA_W    = 8,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  HALT_WORD = 8'h80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef INSTR_MEM_PARITY_EN
  input  logic              prog_par_inv,
  output logic              parity_err,
`endif
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PROG = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] w;
    case (addr)
      ADDR_W'(3'd0): w = DATA_W'(8'h30);
      ADDR_W'(3'd1): w = DATA_W'(8'h40);
      ADDR_W'(3'd2): w = DATA_W'(8'h50);
      ADDR_W'(3'd3): w = DATA_W'(8'h60);
      ADDR_W'(3'd4): w = DATA_W'(8'h72);
      ADDR_W'(3'd5): w = DATA_W'(8'h80);
      default:       w = DATA_W'(HALT_WORD);
    endcase
    return w;
  endfunction

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_nxt_s;
  logic                busy_r;
  logic                fetch_valid_r;
  logic [DATA_W-1:0]   fetch_data_r;
  logic                accept_s;
  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];

`ifdef INSTR_MEM_PARITY_EN
  logic                par_r [DEPTH];
  logic                winv_s;
  logic                parity_err_r;
`endif

  // Next-state, fetch acceptance and shared write-port selection
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    we_s        = 1'b0;
    waddr_s     = cnt_r;
    wdata_s     = boot_word(cnt_r);
`ifdef INSTR_MEM_PARITY_EN
    winv_s      = 1'b0;
`endif
    case (state_r)
      ST_INIT: begin
        we_s = 1'b1;
        // Counter parks at the last address rather than wrapping
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1'b1);
        end
      end
      ST_RUN: begin
        if (prog_en) begin
          state_nxt_s = ST_PROG;
        end else if (fetch_req) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_PROG: begin
        if (!prog_en) begin
          state_nxt_s = ST_RUN;
        end else if (prog_we) begin
          we_s    = 1'b1;
          waddr_s = prog_addr;
          wdata_s = prog_data;
`ifdef INSTR_MEM_PARITY_EN
          winv_s  = prog_par_inv;
`endif
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Control state and registered fetch outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_INIT;
      cnt_r         <= '0;
      busy_r        <= 1'b1;
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= '0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      busy_r        <= (state_nxt_s != ST_RUN);
      fetch_valid_r <= accept_s;
      if (accept_s) begin
        fetch_data_r <= mem_r[fetch_addr];
      end else begin
        fetch_data_r <= fetch_data_r;
      end
    end
  end

  // Storage array; contents are defined only by INIT and PROG writes
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  // Parity bit written alongside each word, optionally inverted for injection
  always_ff @(posedge clk) begin
    if (we_s) begin
      par_r[waddr_s] <= even_parity(wdata_s) ^ winv_s;
    end
  end

  // Parity check qualified by the same acceptance as fetch_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= accept_s & (even_parity(mem_r[fetch_addr]) != par_r[fetch_addr]);
    end
  end

  assign parity_err = parity_err_r;
`endif

  assign fetch_data  = fetch_data_r;
  assign fetch_valid = fetch_valid_r;
  assign busy        = busy_r;

endmodule

// File: doc/instr_mem.md
# instr_mem

Parametrised instruction memory for the CPU fetch path, superseding the fixed 16×8 boot ROM. After reset it self-initialises with the built-in boot program, serves fetch requests with a one-cycle req/valid handshake, and accepts word-by-word reprogramming through a dedicated load port. It sits between the program counter/fetch logic and the decoder.

## Interface
- DATA_W, 8, instruction word width; must be ≥ 8.
- ADDR_W, 4, address width; must be ≥ 3.
- DEPTH, 1<<ADDR_W, number of words; derived, not overridden.
- HALT_WORD, 8'h80, fill value for addresses past the boot program, zero-extended to DATA_W.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  fetch request, sampled each cycle.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_data  out  DATA_W  fetched word; valid while fetch_valid=1.
- fetch_valid  out  1  one-cycle pulse: fetch_data holds the word for the accepted request.
- prog_en  in  1  enter/hold program mode.
- prog_we  in  1  write strobe; honoured only in PROG.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  DATA_W  write data.
- busy  out  1  high in INIT and PROG; fetches are not accepted.

## Operation
- FSM states are INIT, RUN, and PROG. Reset enters INIT.
- INIT: an internal counter walks addresses 0..DEPTH-1, writing one word per cycle.
  - Boot image: addr0=8'h30, 1=8'h40, 2=8'h50, 3=8'h60, 4=8'h72, 5=8'h80 (zero-extended).
  - All other addresses receive HALT_WORD.
  - On the cycle the counter reaches DEPTH-1, the FSM goes to RUN.
- RUN:
  - fetch_req=1 is accepted. mem[fetch_addr] appears on fetch_data next cycle, with fetch_valid=1 for exactly that cycle.
  - Back-to-back requests are accepted every cycle.
  - prog_en=1 moves the FSM to PROG next cycle. A fetch_req in that same cycle is dropped (no valid). Program mode wins.
- PROG:
  - prog_we=1 writes prog_data to mem[prog_addr] at the clock edge.
  - fetch_req is ignored.
  - prog_en=0 returns the FSM to RUN next cycle. A prog_we in that cycle is ignored.
- fetch_data holds its last value when fetch_valid=0. It is never cleared except by reset.
- Addresses are exactly ADDR_W bits, so there is no out-of-range case. The INIT counter stops at DEPTH-1 and does not wrap.
- Reset mid-INIT or mid-PROG aborts immediately. INIT restarts from address 0, and contents are fully rewritten.

## Timing
- Reset values: fetch_data=0, fetch_valid=0, busy=1, state=INIT, INIT counter=0.
- busy is registered and changes in the same cycle as the state.
- INIT lasts exactly DEPTH cycles after rst_n deasserts. busy falls on the edge that enters RUN.
- Fetch latency is 1 cycle from the sampling edge.
- A write in PROG is visible to a fetch accepted on the first RUN cycle.
- Memory array is not reset; only INIT defines contents.

## Configuration
- INSTR_MEM_PARITY_EN: each word stores one extra even-parity bit, computed on every write (INIT and PROG). Extra ports:
  - prog_par_inv (in, 1): inverts the stored parity on a PROG write. Used for error injection.
  - parity_err (out, 1, reset 0): asserted with fetch_valid when the stored parity mismatches the read word.
- Without the macro: no parity storage, and neither port exists.

## Test plan
- Reset, then release rst_n. Required: busy=1 for exactly 16 cycles. Fetches of addr 0..5 return 30,40,50,60,72,80. addr 9 returns 80. Each result arrives one cycle after its request, with a single-cycle fetch_valid.
- In RUN, fetch_req held 4 cycles with addr 3,4,5,0. Required: 4 consecutive valid pulses with data 60,72,80,30.
- prog_en=1, write addr 2=8'hA5, then prog_en=0. Required: fetch_req during PROG gives no fetch_valid. First RUN fetch of addr 2 returns A5.
- fetch_req and prog_en asserted in the same RUN cycle. Required: no fetch_valid, busy=1 next cycle.
- Assert rst_n=0 at INIT cycle 7 after a prior program of addr 2=A5. Required: outputs return to reset values immediately. After a full re-INIT, addr 2 returns 50.
- With INSTR_MEM_PARITY_EN: write addr 1=8'h0F with prog_par_inv=1, then fetch. Required: parity_err=1 together with fetch_valid. Fetching addr 0 gives parity_err=0.
